pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Owns the architectural program counter and sequences instruction fetch for the single-issue MIPS core. Drives the word-addressed instruction-memory request/acknowledge handshake, presents fetched instructions to decode with a valid/ready handshake, and chooses the next PC: sequential PC+1 from the incrementer, or a redirect target from branch/jump resolution. A redirect always takes priority over sequential flow.

Parameters:
RESET_VECTOR, 32'h0000_0000, word address fetched first after reset
TRAP_VECTOR, 32'h0000_0040, word address taken on a bounds fault (PC_BOUNDS_CHECK_EN only)
IMEM_DEPTH, 1024, instruction-memory size in words (PC_BOUNDS_CHECK_EN only)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
redirect_valid  input  1  one-cycle pulse; branch/jump taken
redirect_target  input  32  word address to fetch next when redirect_valid=1
imem_req  output  1  fetch request; held high until imem_ack
imem_addr  output  32  word address of the fetch; stable while imem_req=1
imem_ack  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
if_valid  output  1  if_instr/if_pc valid toward decode
if_ready  input  1  decode accepts the instruction
if_pc  output  32  address of if_instr
if_instr  output  32  fetched instruction
fault  output  1  sticky bounds fault; tied 0 without the macro

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: pc_q=RESET_VECTOR, imem_addr=RESET_VECTOR, imem_req=0, if_valid=0, if_pc=0, if_instr=0, fault=0, state=IDLE.
- Registers: pc_q holds the next fetch address. addr_q drives imem_addr and holds the address of the outstanding request.
- IDLE: on the next clk go to REQ with addr_q<=pc_q and imem_req=1. A redirect in IDLE sets pc_q and addr_q to redirect_target.
- REQ: imem_req=1 and imem_addr=addr_q, both stable until ack.
  - imem_ack=1 without redirect: if_instr<=imem_rdata, if_pc<=addr_q, if_valid<=1, pc_q<=addr_q+1. Go to HOLD. imem_req drops the next cycle.
  - imem_ack=1 with redirect: discard rdata, set pc_q and addr_q to redirect_target, stay in REQ. The new address is driven the next cycle.
  - Redirect with no ack: pc_q<=redirect_target. Go to DRAIN. addr_q is unchanged.
- DRAIN: imem_req=1 with the old addr_q. On imem_ack, discard rdata, set addr_q<=pc_q, go to REQ. A further redirect in DRAIN overwrites pc_q (last redirect wins). Redirect coinciding with the ack sets addr_q to the new target directly.
- HOLD: if_valid=1, and outputs stay stable until if_ready.
  - if_ready=1: if_valid<=0, addr_q<=pc_q, go to REQ. The next request issues the cycle after the handshake.
  - Redirect (with or without if_ready): if_valid<=0 (flush), pc_q and addr_q set to redirect_target, go to REQ. When redirect and if_ready coincide, decode is considered to have accepted the instruction.
- Arithmetic: PC+1 is a 32-bit modulo increment by one word. 32'hFFFF_FFFF wraps to 32'h0, with no flag.
- Throughput: at most one instruction per 3 cycles, assuming single-cycle ack and immediate ready.
- Reset asserted mid-operation: all state returns to the reset values immediately, and any in-flight ack is ignored after reset.
- imem_ack outside REQ/DRAIN is ignored.

Optional Feature:
PC_BOUNDS_CHECK_EN
- Defined: on entry to REQ (before issuing), if addr_q >= IMEM_DEPTH, no request is issued. fault<=1 (sticky until reset), pc_q and addr_q are set to TRAP_VECTOR, and the fetch issues from TRAP_VECTOR the next cycle.
- Undefined: no check is made; fault is tied to 0, and IMEM_DEPTH and TRAP_VECTOR are unused.

Decomposition:
- Package pc_seq_pkg: state enum (IDLE, REQ, DRAIN, HOLD), WORD_W=32, and the default reset and trap vector constants.
- One sub-module, pc_incr: combinational 32-bit +1 wrap-around incrementer, instantiated for addr_q+1.

Test Plan:
- Reset release with a 1-cycle ack memory returning mem[a]=a^32'hA5A5_0000 and if_ready held 1 -> imem_addr sequence 0,1,2,3; if_pc 0,1,2,3 with matching if_instr; one instruction every 3 cycles.
- if_ready held 0 for 5 cycles in HOLD -> if_valid, if_pc, if_instr stable, imem_req=0; the fetch of pc+1 issues the cycle after ready rises.
- Ack delayed 4 cycles, redirect_target=32'h100 pulsed in cycle 2 of the wait -> imem_addr stays at the old address until ack; rdata is discarded; the next request goes to 32'h100 and if_pc=32'h100.
- Redirect to 32'h20 coinciding with if_ready in HOLD at if_pc=5 -> if_valid drops; the next imem_addr is 32'h20, not 6.
- Force pc to 32'hFFFF_FFFF via redirect, with the macro undefined -> fetch at FFFF_FFFF, then the next address is 32'h0.
- PC_BOUNDS_CHECK_EN with IMEM_DEPTH=16 and redirect to 16 -> no request issued at 16; fault=1; the next imem_addr is 32'h40; fault stays 1 until rst_n is asserted.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Optional bounds checking is enabled by defining PC_BOUNDS_CHECK_EN.
package pc_seq_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0040;
    localparam logic [WORD_W-1:0] DEFAULT_IMEM_DEPTH   = 32'd1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } pc_state_e;

    function automatic logic in_bounds(input logic [WORD_W-1:0] addr,
                                       input logic [WORD_W-1:0] depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/pc_incr.sv
// Combinational word-address incrementer; wraps modulo 2^WORD_W with no carry out.
module pc_incr
    import pc_seq_pkg::*;
(
    input  logic [WORD_W-1:0] value,
    output logic [WORD_W-1:0] value_inc
);

    assign value_inc = value + {{(WORD_W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer for the single-issue core.
// Define PC_BOUNDS_CHECK_EN to trap fetches at or beyond IMEM_DEPTH to TRAP_VECTOR.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
`ifdef PC_BOUNDS_CHECK_EN
    ,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
    parameter logic [31:0] IMEM_DEPTH   = DEFAULT_IMEM_DEPTH
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fault
);

    pc_state_e         state_r, state_s;
    logic [WORD_W-1:0] pc_r, pc_s;
    logic [WORD_W-1:0] addr_r, addr_s;
    logic [WORD_W-1:0] addr_inc_s;
    logic              imem_req_r, imem_req_s;
    logic              if_valid_r, if_valid_s;
    logic [WORD_W-1:0] if_pc_r, if_pc_s;
    logic [WORD_W-1:0] if_instr_r, if_instr_s;
    logic              issue_s;

    pc_incr u_incr (
        .value     (addr_r),
        .value_inc (addr_inc_s)
    );

    // Next-state and next-register computation; issue_s marks entry into a fresh request.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        addr_s     = addr_r;
        if_valid_s = if_valid_r;
        if_pc_s    = if_pc_r;
        if_instr_s = if_instr_r;
        issue_s    = 1'b0;
        case (state_r)
            IDLE: begin
                issue_s = 1'b1;
                state_s = REQ;
                if (redirect_valid) begin
                    pc_s   = redirect_target;
                    addr_s = redirect_target;
                end else begin
                    addr_s = pc_r;
                end
            end
            REQ: begin
                if (imem_ack && redirect_valid) begin
                    pc_s    = redirect_target;
                    addr_s  = redirect_target;
                    issue_s = 1'b1;
                    state_s = REQ;
                end else if (imem_ack) begin
                    if_instr_s = imem_rdata;
                    if_pc_s    = addr_r;
                    if_valid_s = 1'b1;
                    pc_s       = addr_inc_s;
                    state_s    = HOLD;
                end else if (redirect_valid) begin
                    // The bus cannot be abandoned mid-request: wait it out in DRAIN.
                    pc_s    = redirect_target;
                    state_s = DRAIN;
                end else begin
                    state_s = REQ;
                end
            end
            DRAIN: begin
                if (imem_ack && redirect_valid) begin
                    pc_s    = redirect_target;
                    addr_s  = redirect_target;
                    issue_s = 1'b1;
                    state_s = REQ;
                end else if (imem_ack) begin
                    addr_s  = pc_r;
                    issue_s = 1'b1;
                    state_s = REQ;
                end else if (redirect_valid) begin
                    pc_s    = redirect_target;
                    state_s = DRAIN;
                end else begin
                    state_s = DRAIN;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    if_valid_s = 1'b0;
                    pc_s       = redirect_target;
                    addr_s     = redirect_target;
                    issue_s    = 1'b1;
                    state_s    = REQ;
                end else if (if_ready) begin
                    if_valid_s = 1'b0;
                    addr_s     = pc_r;
                    issue_s    = 1'b1;
                    state_s    = REQ;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
`ifdef PC_BOUNDS_CHECK_EN
        if (issue_s && !in_bounds(addr_s, IMEM_DEPTH)) begin
            pc_s   = TRAP_VECTOR;
            addr_s = TRAP_VECTOR;
        end else begin
            addr_s = addr_s;
        end
`endif
        imem_req_s = (state_s == REQ) || (state_s == DRAIN);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= RESET_VECTOR;
            addr_r     <= RESET_VECTOR;
            imem_req_r <= 1'b0;
            if_valid_r <= 1'b0;
            if_pc_r    <= 32'h0000_0000;
            if_instr_r <= 32'h0000_0000;
        end else begin
            pc_r       <= pc_s;
            addr_r     <= addr_s;
            imem_req_r <= imem_req_s;
            if_valid_r <= if_valid_s;
            if_pc_r    <= if_pc_s;
            if_instr_r <= if_instr_s;
        end
    end

`ifdef PC_BOUNDS_CHECK_EN
    logic fault_r;

    // Sticky bounds fault, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_r <= 1'b0;
        end else if (issue_s && !in_bounds(addr_s, IMEM_DEPTH)) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end

    assign fault = fault_r;
`else
    assign fault = 1'b0;
`endif

    assign imem_req  = imem_req_r;
    assign imem_addr = addr_r;
    assign if_valid  = if_valid_r;
    assign if_pc     = if_pc_r;
    assign if_instr  = if_instr_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: transaction-level fetch model plus directed scenarios.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fault;

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int cyc   = 0;
    int ack_cnt;

    always #5 clk = ~clk;

`ifdef PC_BOUNDS_CHECK_EN
    pc_sequencer #(.IMEM_DEPTH(32'd16)) dut (
`else
    pc_sequencer dut (
`endif
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .fault           (fault)
    );

    // Instruction memory: contents a ^ A5A5_0000, ack after `lat` cycles of request.
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_ack <= 1'b0;
            ack_cnt  <= 0;
        end else if (imem_req && !imem_ack) begin
            if (ack_cnt + 1 >= lat) begin
                imem_ack <= 1'b1;
                ack_cnt  <= 0;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end else begin
            imem_ack <= 1'b0;
            ack_cnt  <= 0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: next fetch address, pending deliveries, handshake rules.
    logic [31:0] exp_addr, cur_addr, p_pc, p_instr, e_addr;
    logic        p_req, p_ack, p_valid, p_ready, p_redir, taint, new_req;
    logic [31:0] dq_pc[$];
    logic [31:0] dq_instr[$];
    logic [31:0] req_log[$];
    int          rise_cyc[$];

    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            exp_addr = 32'h0;
            cur_addr = 32'h0;
            taint = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0;
            p_ready = 1'b0; p_redir = 1'b0; p_pc = 32'h0; p_instr = 32'h0;
            dq_pc.delete(); dq_instr.delete(); req_log.delete(); rise_cyc.delete();
        end else begin
            new_req = imem_req && (!p_req || p_ack);
            if (new_req) begin
                e_addr = exp_addr;
`ifdef PC_BOUNDS_CHECK_EN
                if (e_addr >= 32'd16) e_addr = 32'h40;
`endif
                check("req_addr", imem_addr, e_addr);
                cur_addr = imem_addr;
                taint = 1'b0;
                req_log.push_back(imem_addr);
            end else if (imem_req) begin
                check("req_addr_stable", imem_addr, cur_addr);
            end
            if (if_valid) check("req_during_valid", 32'(imem_req), 32'd0);
            if (if_valid && !p_valid) begin
                rise_cyc.push_back(cyc);
                if (dq_pc.size() == 0) begin
                    check("unexpected_valid", 32'(if_valid), 32'd0);
                end else begin
                    check("if_pc", if_pc, dq_pc.pop_front());
                    check("if_instr", if_instr, dq_instr.pop_front());
                end
            end else if (if_valid && p_valid) begin
                check("valid_after_handshake", 32'(p_ready | p_redir), 32'd0);
                check("if_pc_stable", if_pc, p_pc);
                check("if_instr_stable", if_instr, p_instr);
            end else if (!if_valid && p_valid) begin
                check("valid_drop_cause", 32'(p_ready | p_redir), 32'd1);
            end
            if (imem_req && imem_ack) begin
                if (!redirect_valid && !taint) begin
                    dq_pc.push_back(imem_addr);
                    dq_instr.push_back(imem_addr ^ 32'hA5A5_0000);
                    exp_addr = imem_addr + 32'd1;
                end
            end else if (imem_req && redirect_valid) begin
                taint = 1'b1;
            end
            if (redirect_valid) exp_addr = redirect_target;
            p_req = imem_req; p_ack = imem_ack; p_valid = if_valid;
            p_ready = if_ready; p_redir = redirect_valid;
            p_pc = if_pc; p_instr = if_instr;
        end
    end

    task automatic do_reset(input int l, input logic rdy);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        lat = l;
        if_ready = rdy;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_valid_pc(input logic [31:0] pc, input logic any, input int bound);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (if_valid && (any || if_pc == pc)) ok = 1'b1;
        end
        if (!ok) check("timeout_valid", 32'(ok), 32'd1);
    endtask

    task automatic wait_req(input int bound);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (imem_req) ok = 1'b1;
        end
        if (!ok) check("timeout_req", 32'(ok), 32'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] tgt);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        // Sequential fetch, 1-cycle ack, decode always ready.
        do_reset(1, 1'b1);
        repeat (14) @(negedge clk);
        check("t1_req_count", 32'(req_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < req_log.size(); i++) check("t1_req_seq", req_log[i], 32'(i));
        for (int i = 1; i < 4 && i < rise_cyc.size(); i++)
            check("t1_spacing", 32'(rise_cyc[i] - rise_cyc[i-1]), 32'd3);

        // Decode stalls for 5 cycles in HOLD.
        do_reset(1, 1'b0);
        wait_valid_pc(32'h0, 1'b1, 10);
        check("t2_pc", if_pc, 32'h0);
        check("t2_instr", if_instr, 32'hA5A5_0000);
        repeat (5) @(negedge clk);
        check("t2_hold_valid", 32'(if_valid), 32'd1);
        check("t2_hold_req", 32'(imem_req), 32'd0);
        check("t2_hold_instr", if_instr, 32'hA5A5_0000);
        #1 if_ready = 1'b1;
        @(negedge clk);
        check("t2_valid_drop", 32'(if_valid), 32'd0);
        check("t2_req_after", 32'(imem_req), 32'd1);
        check("t2_addr_after", imem_addr, 32'h1);

`ifndef PC_BOUNDS_CHECK_EN
        // Slow memory, redirect during the outstanding request.
        do_reset(4, 1'b1);
        wait_req(10);
        @(posedge clk);
        #1;
        pulse_redirect(32'h100);
        @(negedge clk);
        check("t3_drain_req", 32'(imem_req), 32'd1);
        check("t3_drain_addr", imem_addr, 32'h0);
        wait_valid_pc(32'h0, 1'b1, 30);
        check("t3_pc", if_pc, 32'h100);
        check("t3_instr", if_instr, 32'hA5A5_0100);
        if (req_log.size() >= 2) begin
            check("t3_req0", req_log[0], 32'h0);
            check("t3_req1", req_log[1], 32'h100);
        end else begin
            check("t3_req_count", 32'(req_log.size()), 32'd2);
        end

        // Redirect coinciding with the decode handshake at pc 5.
        do_reset(1, 1'b1);
        wait_valid_pc(32'h5, 1'b0, 40);
        #1;
        pulse_redirect(32'h20);
        @(negedge clk);
        check("t4_valid", 32'(if_valid), 32'd0);
        check("t4_req", 32'(imem_req), 32'd1);
        check("t4_addr", imem_addr, 32'h20);

        // Wrap from the last word address back to zero.
        do_reset(1, 1'b1);
        wait_valid_pc(32'h0, 1'b1, 10);
        #1;
        pulse_redirect(32'hFFFF_FFFF);
        wait_valid_pc(32'hFFFF_FFFF, 1'b0, 10);
        check("t5_instr", if_instr, 32'h5A5A_FFFF);
        wait_req(5);
        check("t5_wrap_addr", imem_addr, 32'h0);
        check("t5_fault", 32'(fault), 32'd0);
`else
        // Redirect past the memory end traps and raises the sticky fault.
        do_reset(1, 1'b1);
        wait_valid_pc(32'h0, 1'b1, 10);
        #1;
        pulse_redirect(32'd16);
        @(negedge clk);
        check("t6_req", 32'(imem_req), 32'd1);
        check("t6_addr", imem_addr, 32'h40);
        check("t6_fault", 32'(fault), 32'd1);
        repeat (10) @(negedge clk);
        check("t6_fault_sticky", 32'(fault), 32'd1);
        do_reset(1, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
